// File: rtl/fir_filter.sv
// fir_filter: direct-form FIR over signed fixed-point samples.
// Coefficients are Q1.15 and arrive as a live port array, so a tap set with
// unity DC gain keeps the output in the same scale as the input. One sample
// is consumed and one rounded, saturated output is registered every clock.
module fir_filter #(
    parameter int TAPS = 16,
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] xn,
    input  logic signed [DW-1:0] coef [TAPS],
    output logic signed [DW-1:0] yn
);

    // Full-precision product width, guard bits for the tap sum, and the
    // number of fractional coefficient bits removed when rescaling.
    localparam int PW   = 2 * DW;
    localparam int GW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int AW   = PW + GW;
    localparam int FRAC = DW - 1;

    // Half an output LSB, used for round-half-up before the shift.
    localparam logic signed [AW-1:0] ROUND =
        {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    // Output range limits expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Delay line: d[i] holds the sample seen i+1 edges ago.
    logic signed [DW-1:0] d [TAPS-1];

    // tap[i] is the sample delayed by i cycles; tap[0] is the live input.
    logic signed [DW-1:0] tap [TAPS];

    // Per-tap full-precision products.
    logic signed [PW-1:0] prod [TAPS];

    // Tap sum and the rescaling chain.
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] rounded;
    logic signed [AW-1:0] scaled;
    logic signed [DW-1:0] y_sat;

    // Assemble the tap vector: current input followed by the delay line.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the values just computed; clocked state below uses '<=' instead.
        tap[0] = xn;
        for (int i = 1; i < TAPS; i++) begin
            tap[i] = d[i-1];
        end
    end

    // Multiply each tap by its coefficient at full double width, so even
    // the most negative value squared is represented exactly.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod[i] = $signed({{DW{coef[i][DW-1]}}, coef[i]})
                    * $signed({{DW{tap[i][DW-1]}}, tap[i]});
        end
    end

    // Sum all products in a widened accumulator; the guard bits make the
    // worst case of every tap at full negative scale fit without overflow.
    always_comb begin
        // NOTE: the accumulator gets a value before the loop on every pass,
        // so no path leaves it unassigned and no latch is inferred.
        acc = '0;
        for (int i = 0; i < TAPS; i++) begin
            acc = acc + $signed({{GW{prod[i][PW-1]}}, prod[i]});
        end
    end

    // Round half up, drop the Q1.15 fraction, then clamp to the output range.
    always_comb begin
        rounded = acc + ROUND;
        scaled  = rounded >>> FRAC;
        if (scaled > SAT_MAX) begin
            y_sat = SAT_MAX[DW-1:0];
        end else if (scaled < SAT_MIN) begin
            y_sat = SAT_MIN[DW-1:0];
        end else begin
            y_sat = scaled[DW-1:0];
        end
    end

    // Shift the delay line and register the output; reset wins over update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the delay line is cleared on reset because it is sample
            // history that must read as zero after release, not a data
            // store; it is a small register chain, not a RAM.
            for (int i = 0; i < TAPS-1; i++) begin
                d[i] <= '0;
            end
            yn <= '0;
        end else begin
            d[0] <= xn;
            for (int i = 1; i < TAPS-1; i++) begin
                d[i] <= d[i-1];
            end
            yn <= y_sat;
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed checks of the 16-tap FIR against hand-computed
// outputs covering reset, impulse, DC steps, saturation, extreme products
// and reset in the middle of a stream.
module tb_fir_filter;

    localparam int TAPS = 16;
    localparam int DW   = 16;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] xn;
    logic signed [DW-1:0] coef [TAPS];
    logic signed [DW-1:0] yn;

    int n_cmp;
    int n_fail;

    // Low-pass tap set (sums to 32758, just under unity gain).
    int lp [TAPS] = '{338, 533, 1080, 1872, 2754, 3550, 4102, 4300,
                      4102, 3550, 2754, 1872, 1080, 533, 338, 0};

    // Step response of the low-pass set to xn=1000 from empty history:
    // floor((1000 * partial_sum + 16384) / 32768) for each edge.
    int step1000 [TAPS] = '{10, 27, 60, 117, 201, 309, 434, 565,
                            691, 799, 883, 940, 973, 989, 1000, 1000};

    fir_filter #(
        .TAPS (TAPS),
        .DW   (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .xn    (xn),
        .coef  (coef),
        .yn    (yn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the registered output against an expected value.
    task automatic check(input string tag, input logic signed [DW-1:0] exp);
        n_cmp++;
        assert (yn === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, yn, exp);
        end
    endtask

    task automatic load_lowpass();
        for (int i = 0; i < TAPS; i++) coef[i] = 16'(lp[i]);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        load_lowpass();

        // Reset held for two edges with a nonzero input.
        rst_n = 1'b0;
        xn    = 16'sd1234;
        tick(); check("rst_hold0", 16'sd0);
        tick(); check("rst_hold1", 16'sd0);
        rst_n = 1'b1;
        xn    = 16'sd0;
        for (int k = 0; k < 3; k++) begin
            tick(); check("rst_release", 16'sd0);
        end

        // Impulse: full tap response over 16 outputs, then zero.
        for (int k = 0; k <= TAPS; k++) begin
            xn = (k == 0) ? 16'sd32767 : 16'sd0;
            tick();
            check("impulse", (k < TAPS) ? 16'(lp[k]) : 16'sd0);
        end

        // Positive DC step from empty history.
        xn = 16'sd1000;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("dc_pos", (k < TAPS) ? 16'(step1000[k]) : 16'sd1000);
        end

        // Negative DC: only the settled value is checked.
        xn = -16'sd1000;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k >= TAPS-1) check("dc_neg", -16'sd1000);
        end

        // Settle at +1000, then reset for a single edge mid-stream.
        xn = 16'sd1000;
        for (int k = 0; k < TAPS; k++) tick();
        check("mid_settled", 16'sd1000);
        rst_n = 1'b0;
        tick(); check("mid_rst_edge", 16'sd0);
        rst_n = 1'b1;
        for (int k = 0; k < TAPS+2; k++) begin
            tick();
            check("mid_step", (k < TAPS) ? 16'(step1000[k]) : 16'sd1000);
        end

        // Saturation with every coefficient at +32767.
        for (int i = 0; i < TAPS; i++) coef[i] = 16'sd32767;
        rst_n = 1'b0;
        tick(); check("sat_rst", 16'sd0);
        rst_n = 1'b1;
        xn = 16'sd32767;
        tick(); check("sat_pos_first", 16'sd32766);
        for (int k = 1; k < 20; k++) begin
            tick(); check("sat_pos", 16'sd32767);
        end
        // Swing to full negative: half-and-half history gives -8, then clamp.
        xn = -16'sd32768;
        for (int m = 1; m <= 24; m++) begin
            tick();
            if (m == 1)  check("sat_neg_first", 16'sd32767);
            if (m == 8)  check("sat_neg_mid", -16'sd8);
            if (m >= 16) check("sat_neg", -16'sd32768);
        end

        // Extreme product on a single tap; history is cleared first.
        for (int i = 0; i < TAPS; i++) coef[i] = 16'sd0;
        coef[0] = -16'sd32768;
        rst_n = 1'b0;
        tick(); check("ext_rst", 16'sd0);
        rst_n = 1'b1;
        xn = -16'sd32768;
        tick(); check("ext_maxneg_sq", 16'sd32767);
        xn = 16'sd100;
        tick(); check("ext_neg_gain", -16'sd100);
        xn = 16'sd0;
        tick(); check("ext_zero", 16'sd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
